// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer with PC, valid/ready output stage and redirect
//   clk, reset        - clock, synchronous active-high reset
//   redirect_valid/pc - load a new byte PC (branch/jump), highest priority
//   imem_req/addr     - fetch request and word index (pc >> 2)
//   imem_rdata/valid  - instruction word and its valid strobe from program memory
//   inst_valid/ready  - output handshake for inst_out / inst_pc
//   fetch_fault       - misaligned redirect trap (only with FETCH_MISALIGN_TRAP_EN)
// Optional macro FETCH_MISALIGN_TRAP_EN enables the HALT state on misaligned redirects.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        fetch_fault
);
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif
    state_t      state, state_n;
    logic [63:0] pc, pc_n, inst_pc_n;
    logic [31:0] inst_out_n;
    logic        inst_valid_n, redirect, accept;
    assign redirect  = redirect_valid && (state == FETCH || state == HOLD);
    assign imem_req  = state == FETCH && !redirect_valid && (!inst_valid || inst_ready);
    assign accept    = imem_req && imem_valid;
    assign imem_addr = {2'b00, pc[63:2]};
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = state == HALT;
`else
    assign fetch_fault = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst_valid <= inst_valid_n;
            inst_out   <= inst_out_n;
            inst_pc    <= inst_pc_n;
        end
    end
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_valid_n = inst_valid;
        inst_out_n   = inst_out;
        inst_pc_n    = inst_pc;
        if (state == IDLE) begin
            state_n = FETCH;
        end else if (redirect) begin
            inst_valid_n = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_n    = redirect_pc;
            state_n = |redirect_pc[1:0] ? HALT : FETCH;
`else
            pc_n    = redirect_pc & ~64'd3;
            state_n = FETCH;
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        else if (state == HALT) begin
            state_n = HALT;
        end
`endif
        else begin
            if (accept) begin
                inst_out_n   = imem_rdata;
                inst_pc_n    = pc;
                inst_valid_n = 1'b1;
                pc_n         = pc + 64'd4;
            end else if (inst_valid && inst_ready) begin
                inst_valid_n = 1'b0;
            end
            // a stalled consumer parks the FSM in HOLD; accept implies no stall
            state_n = (inst_valid && !inst_ready) ? HOLD : FETCH;
        end
    end
endmodule
